// File: rtl/torrence_types.sv
// Shared types for the memory-side blocks: operation sizes, arbiter states
// and the fixed requester numbering used by the miss ports.
package torrence_types;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_LINE = 2'd3
  } memory_operation_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic ICACHE_PORT = 1'b0;
  localparam logic DCACHE_PORT = 1'b1;

endpackage

// File: rtl/counter.sv
// Loadable up/down counter with an optional terminal-count flag.
module counter #(
  parameter int WIDTH          = 3,
  parameter bit DOWN           = 1'b1,
  parameter bit CHECK_FOR_DONE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= DOWN ? (count - WIDTH'(1)) : (count + WIDTH'(1));
    end
  end

  // Terminal count is zero when counting down, all-ones when counting up.
  assign done = CHECK_FOR_DONE && (DOWN ? (count == '0) : (&count));

endmodule

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter granting whole cache-line bursts on the single
// main-memory port; port 0 is the I-cache miss port, port 1 the D-cache.
module memory_arbiter
  import torrence_types::*;
#(
  parameter int XLEN      = 32,
  parameter int LINE_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           rq_valid,
  input  logic [1:0]           rq_op,
  input  logic [1:0][1:0]      rq_size,
  input  logic [1:0][XLEN-1:0] rq_address,
  input  logic [1:0][XLEN-1:0] rq_store_word,
  output logic [1:0]           rq_fulfilled,
  output logic [1:0][XLEN-1:0] rq_loaded_word,
  output logic                 mem_valid,
  output logic                 mem_op,
  output logic [1:0]           mem_size,
  output logic [XLEN-1:0]      mem_address,
  output logic [XLEN-1:0]      mem_store_word,
  input  logic                 mem_fulfilled,
  input  logic [XLEN-1:0]      mem_loaded_word,
  output logic                 owner,
  output logic                 busy
);

  localparam int WORDS_PER_LINE = LINE_SIZE / 4;
  localparam int CW             = $clog2(WORDS_PER_LINE);

  arb_state_e state, state_next;
  logic       last_grant;
  logic       grant;
  logic       port;
  logic       owned;
  logic       fire;
  logic       cnt_load, cnt_en, cnt_clear, cnt_done;

  assign owned = (state != IDLE);
  assign port  = (state == OWN1);
  assign fire  = mem_valid & mem_fulfilled;

  counter #(
    .WIDTH         (CW),
    .DOWN          (1'b1),
    .CHECK_FOR_DONE(1'b1)
  ) u_burst_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clear),
    .load      (cnt_load),
    .load_value(CW'(WORDS_PER_LINE - 1)),
    .enable    (cnt_en),
    .done      (cnt_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if (cnt_load) last_grant <= grant;
    end
  end

  always_comb begin
    state_next = state;
    grant      = last_grant;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    cnt_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (|rq_valid) begin
          // On a tie the port that did not win last time goes next.
          grant      = (&rq_valid) ? ~last_grant : rq_valid[DCACHE_PORT];
          cnt_load   = 1'b1;
          state_next = grant ? OWN1 : OWN0;
        end
      end
      OWN0, OWN1: begin
        if (fire) begin
          if (cnt_done) begin
            state_next = IDLE;
            cnt_clear  = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end else if (!rq_valid[port]) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_valid      = 1'b0;
    mem_op         = 1'b0;
    mem_size       = 2'd0;
    mem_address    = '0;
    mem_store_word = '0;
    rq_fulfilled   = 2'b00;
    rq_loaded_word = '0;
    if (owned) begin
      mem_valid            = rq_valid[port];
      mem_op               = rq_op[port];
      mem_size             = rq_size[port];
      mem_address          = rq_address[port];
      mem_store_word       = rq_store_word[port];
      rq_fulfilled[port]   = fire;
      rq_loaded_word[port] = mem_loaded_word;
    end
  end

  assign owner = last_grant;
  assign busy  = owned;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: single bursts, round-robin ties, abort,
// mid-burst reset and spurious memory responses.
module tb_memory_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       rq_valid;
  logic [1:0]       rq_op;
  logic [1:0][1:0]  rq_size;
  logic [1:0][31:0] rq_address;
  logic [1:0][31:0] rq_store_word;
  logic [1:0]       rq_fulfilled;
  logic [1:0][31:0] rq_loaded_word;
  logic             mem_valid;
  logic             mem_op;
  logic [1:0]       mem_size;
  logic [31:0]      mem_address;
  logic [31:0]      mem_store_word;
  logic             mem_fulfilled;
  logic [31:0]      mem_loaded_word;
  logic             owner;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  memory_arbiter #(.XLEN(32), .LINE_SIZE(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .rq_valid       (rq_valid),
    .rq_op          (rq_op),
    .rq_size        (rq_size),
    .rq_address     (rq_address),
    .rq_store_word  (rq_store_word),
    .rq_fulfilled   (rq_fulfilled),
    .rq_loaded_word (rq_loaded_word),
    .mem_valid      (mem_valid),
    .mem_op         (mem_op),
    .mem_size       (mem_size),
    .mem_address    (mem_address),
    .mem_store_word (mem_store_word),
    .mem_fulfilled  (mem_fulfilled),
    .mem_loaded_word(mem_loaded_word),
    .owner          (owner),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
    chk({tag, "_rq_fulfilled"}, 64'(rq_fulfilled), 64'd0);
  endtask

  // Runs n fulfilled beats on an already-granted port, words first..first+n-1.
  task automatic do_burst(input int port, input int first, input int n);
    logic [31:0] base;
    logic [31:0] data;
    base = (port == 1) ? 32'h0000_2000 : 32'h0000_0100;
    for (int k = 0; k < n; k++) begin
      rq_address[port] = base + 32'(4 * (first + k));
      data             = 32'hC0DE_0000 + 32'(port * 256 + first + k);
      mem_loaded_word  = data;
      mem_fulfilled    = 1'b1;
      @(negedge clk);
      chk("burst_mem_valid", 64'(mem_valid), 64'd1);
      chk("burst_busy", 64'(busy), 64'd1);
      chk("burst_owner", 64'(owner), 64'(port));
      chk("burst_rq_fulfilled", 64'(rq_fulfilled), 64'(1) << port);
      chk("burst_mem_address", 64'(mem_address), 64'(base + 32'(4 * (first + k))));
      chk("burst_mem_op", 64'(mem_op), 64'(port));
      chk("burst_mem_size", 64'(mem_size), (port == 1) ? 64'd3 : 64'd2);
      chk("burst_mem_store_word", 64'(mem_store_word),
          (port == 1) ? 64'h5A5A_0000 : 64'hA5A5_0000);
      chk("burst_loaded_owner", 64'(rq_loaded_word[port]), 64'(data));
      chk("burst_loaded_other", 64'(rq_loaded_word[1-port]), 64'd0);
      tick();
    end
  endtask

  initial begin
    reset           = 1'b0;
    rq_valid        = 2'b00;
    rq_op           = 2'b10;
    rq_size[0]      = 2'd2;
    rq_size[1]      = 2'd3;
    rq_address      = '0;
    rq_store_word[0] = 32'hA5A5_0000;
    rq_store_word[1] = 32'h5A5A_0000;
    mem_fulfilled   = 1'b0;
    mem_loaded_word = 32'h0;

    tick();
    @(negedge clk);
    chk("rst_owner", 64'(owner), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_rq_fulfilled", 64'(rq_fulfilled), 64'd0);
    chk("rst_loaded", 64'(rq_loaded_word), 64'd0);
    tick();
    reset = 1'b1;

    // Single requester, memory answers every cycle.
    rq_valid      = 2'b01;
    rq_address[0] = 32'h100;
    mem_fulfilled = 1'b1;
    check_idle("t1_idle");
    tick();
    do_burst(0, 0, 8);
    check_idle("t1_end");
    chk("t1_owner", 64'(owner), 64'd0);
    rq_valid = 2'b00;
    tick();

    // Ties from reset alternate 0,1,0,1 with a bubble between bursts.
    reset = 1'b0;
    tick();
    reset    = 1'b1;
    rq_valid = 2'b11;
    check_idle("t2_idle");
    tick();
    for (int b = 0; b < 4; b++) begin
      do_burst(b % 2, 0, 8);
      check_idle("t2_bubble");
      chk("t2_owner", 64'(owner), 64'(b % 2));
      if (b == 3) rq_valid = 2'b00;
      tick();
    end

    // Abort after three beats, then a fresh full burst.
    rq_valid = 2'b10;
    tick();
    do_burst(1, 0, 3);
    rq_valid = 2'b00;
    @(negedge clk);
    chk("t4_drop_mem_valid", 64'(mem_valid), 64'd0);
    chk("t4_drop_fulfilled", 64'(rq_fulfilled), 64'd0);
    tick();
    check_idle("t4_aborted");
    rq_valid = 2'b10;
    tick();
    do_burst(1, 0, 8);
    check_idle("t4_refill_end");
    rq_valid = 2'b00;
    tick();

    // Reset in the middle of a burst.
    rq_valid = 2'b01;
    tick();
    do_burst(0, 0, 5);
    reset = 1'b0;
    #1;
    chk("t5_mem_valid", 64'(mem_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_owner", 64'(owner), 64'd1);
    chk("t5_fulfilled", 64'(rq_fulfilled), 64'd0);
    tick();
    reset    = 1'b1;
    rq_valid = 2'b11;
    check_idle("t5_idle");
    tick();
    do_burst(0, 0, 8);
    check_idle("t5_end");
    rq_valid = 2'b00;
    tick();

    // Spurious response in IDLE and a stall mid-burst.
    mem_fulfilled = 1'b1;
    check_idle("t6_spurious");
    tick();
    rq_valid      = 2'b01;
    mem_fulfilled = 1'b0;
    check_idle("t6_req");
    tick();
    do_burst(0, 0, 4);
    mem_fulfilled = 1'b0;
    @(negedge clk);
    chk("t6_stall_fulfilled", 64'(rq_fulfilled), 64'd0);
    chk("t6_stall_busy", 64'(busy), 64'd1);
    chk("t6_stall_mem_valid", 64'(mem_valid), 64'd1);
    tick();
    do_burst(0, 4, 4);
    check_idle("t6_end");
    rq_valid = 2'b00;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
